// File: rtl/b12_trace_capture_if.sv
// Read port of the b12 trace FIFO: head entry offered with valid/ready.
interface b12_trace_capture_if #(
    parameter int unsigned W = 23
) ();
    logic         rd_valid;
    logic         rd_ready;
    logic [W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/b12_trace_capture.sv
// Timestamped response recorder for the b12 core; change/marker/wrap-triggered FIFO trace.
// Optional B12_TRACE_STOP_ON_FULL_EN: first dropped entry halts the capture run.
module b12_trace_capture #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned TS_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     obs,
    input  logic                     nloss,
    input  logic [3:0]               nl,
    input  logic                     speaker,
    b12_trace_capture_if.master      rd,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     capturing
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = 6;
    localparam int unsigned EW = TS_W + 7;

    typedef enum logic [1:0] {IDLE, CAPTURE, HALT} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [TS_W-1:0] ts;
    logic [SW-1:0]   prev;
    logic            first;
    logic [EW-1:0]   mem [DEPTH];

    logic [SW-1:0]   s;
    logic            valid, pop, rec, push, drop, arm_fire, sample_en;

    assign s     = {nloss, nl, speaker};
    assign valid = (level != '0);
    assign pop   = valid && rd.rd_ready;
    assign rec   = sample_en && (first || (s != prev) || obs || (ts == '0));
    assign push  = rec && ((level < LW'(DEPTH)) || pop);
    assign drop  = rec && !push;

    assign rd.rd_valid = valid;
    // Gate with valid so the port reads zero after reset, independent of stale memory.
    assign rd.rd_data  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state plus the per-cycle sample/arm strobes; stop beats arm.
    always_comb begin
        state_next = state;
        sample_en  = 1'b0;
        arm_fire   = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (arm && !stop) begin
                    state_next = CAPTURE;
                    arm_fire   = 1'b1;
                end
            end
            CAPTURE: begin
                if (stop) begin
                    state_next = HALT;
                end else begin
                    sample_en = 1'b1;
`ifdef B12_TRACE_STOP_ON_FULL_EN
                    if (drop) state_next = HALT;
`else
                    state_next = CAPTURE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            ts        <= '0;
            prev      <= '0;
            first     <= 1'b0;
            overflow  <= 1'b0;
            capturing <= 1'b0;
        end else begin
            capturing <= (state_next == CAPTURE);
            if (arm_fire) begin
                ts       <= '0;
                first    <= 1'b1;
                overflow <= 1'b0;
            end else if (sample_en) begin
                ts    <= ts + TS_W'(1);
                first <= 1'b0;
                prev  <= s;
                if (drop) overflow <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is readable.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {ts, obs, s};
    end
endmodule

// File: tb/tb_b12_trace_capture.sv
// Directed bench for b12_trace_capture (DEPTH=4, TS_W=4) with hand-computed entries.
module tb_b12_trace_capture;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TS_W  = 4;
    localparam int unsigned EW    = TS_W + 7;

    logic       clock = 1'b0;
    logic       reset, arm, stop, obs, nloss, speaker;
    logic [3:0] nl;
    logic [2:0] level;
    logic       overflow, capturing;
    int         n_checks = 0;
    int         n_pass   = 0;

    b12_trace_capture_if #(.W(EW)) rd_if ();

    b12_trace_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .arm       (arm),
        .stop      (stop),
        .obs       (obs),
        .nloss     (nloss),
        .nl        (nl),
        .speaker   (speaker),
        .rd        (rd_if.master),
        .level     (level),
        .overflow  (overflow),
        .capturing (capturing)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [EW-1:0] entry(input int t, input logic o, input logic [3:0] n, input logic sp);
        return {TS_W'(t), o, 1'b0, n, sp};
    endfunction

    task automatic pop_check(input string tag, input logic [EW-1:0] exp);
        check({tag, "_valid"}, 32'(rd_if.rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_if.rd_data), 32'(exp));
        rd_if.rd_ready = 1'b1;
        tick();
        rd_if.rd_ready = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; stop = 1'b0; obs = 1'b0; nloss = 1'b0;
        nl = 4'h0; speaker = 1'b0; rd_if.rd_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(rd_if.rd_valid), 32'd0);
        check("rst_data", 32'(rd_if.rd_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_cap", 32'(capturing), 32'd0);

        // Constant inputs: only the first-cycle record.
        nl = 4'h3;
        do_arm();
        check("arm_cap", 32'(capturing), 32'd1);
        check("arm_level", 32'(level), 32'd0);
        for (int k = 0; k < 10; k++) tick();
        check("const_level", 32'(level), 32'd1);
        do_stop();
        check("stop_cap", 32'(capturing), 32'd0);
        pop_check("const_e0", 11'h006);
        check("const_empty", 32'(level), 32'd0);

        // Speaker toggles at 5 and 8, obs pulse at 12.
        do_arm();
        for (int k = 0; k <= 12; k++) begin
            if (k == 5) speaker = 1'b1;
            if (k == 8) speaker = 1'b0;
            obs = (k == 12);
            tick();
        end
        obs = 1'b0;
        do_stop();
        check("chg_level", 32'(level), 32'd4);
        check("chg_ovf", 32'(overflow), 32'd0);
        pop_check("chg_e0", 11'h006);
        pop_check("chg_e5", 11'h287);
        pop_check("chg_e8", 11'h406);
        pop_check("chg_e12", 11'h646);
        rd_if.rd_ready = 1'b1;
        tick();
        rd_if.rd_ready = 1'b0;
        check("underflow", 32'(level), 32'd0);

        // Timestamp wrap forces a record; arm mid-capture must not restart.
        do_arm();
        for (int k = 0; k < 20; k++) begin
            arm = (k == 10);
            tick();
        end
        arm = 1'b0;
        do_stop();
        check("wrap_level", 32'(level), 32'd2);
        pop_check("wrap_e0", 11'h006);
        pop_check("wrap_e16", 11'h006);

        // Overflow: nl changes every cycle with the consumer stalled.
        do_arm();
        for (int k = 0; k < 6; k++) begin
            nl = 4'(k + 4);
            tick();
            if (k == 3) check("full_ovf0", 32'(overflow), 32'd0);
            if (k == 4) begin
                check("full_ovf1", 32'(overflow), 32'd1);
`ifdef B12_TRACE_STOP_ON_FULL_EN
                check("full_cap", 32'(capturing), 32'd0);
`else
                check("full_cap", 32'(capturing), 32'd1);
`endif
            end
        end
        check("full_level", 32'(level), 32'd4);
        check("full_ovf", 32'(overflow), 32'd1);
`ifdef B12_TRACE_STOP_ON_FULL_EN
        for (int k = 0; k < 4; k++) pop_check("full_e", entry(k, 1'b0, 4'(k + 4), 1'b0));
`else
        nl = 4'hA;
        rd_if.rd_ready = 1'b1;
        tick();
        rd_if.rd_ready = 1'b0;
        check("swap_level", 32'(level), 32'd4);
        do_stop();
        check("swap_ovf", 32'(overflow), 32'd1);
        for (int k = 1; k < 4; k++) pop_check("swap_e", entry(k, 1'b0, 4'(k + 4), 1'b0));
        pop_check("swap_e6", entry(6, 1'b0, 4'hA, 1'b0));
`endif
        check("drain_level", 32'(level), 32'd0);

        // Re-arm clears overflow; then reset mid-run with three entries buffered.
        do_arm();
        check("rearm_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 3; k++) begin
            nl = 4'(k);
            tick();
        end
        check("mid_level", 32'(level), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_level", 32'(level), 32'd0);
        check("mr_valid", 32'(rd_if.rd_valid), 32'd0);
        check("mr_data", 32'(rd_if.rd_data), 32'd0);
        check("mr_ovf", 32'(overflow), 32'd0);
        check("mr_cap", 32'(capturing), 32'd0);

        // arm+stop together in IDLE: stays idle and records nothing.
        arm = 1'b1; stop = 1'b1;
        tick();
        arm = 1'b0; stop = 1'b0;
        check("as_cap", 32'(capturing), 32'd0);
        for (int k = 0; k < 3; k++) begin
            nl = 4'(k + 7);
            obs = 1'b1;
            tick();
        end
        obs = 1'b0;
        check("idle_level", 32'(level), 32'd0);
        check("idle_cap", 32'(capturing), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/b12_trace_capture.md
# b12_trace_capture

Synthesizable response recorder for the b12 game core: the observing end of the stimulus interface that drives `__obs`, `k` and `start` into the core. It samples the core's outputs (`nloss`, `nl`, `speaker`) together with the `__obs` marker every cycle. It stores a timestamped entry only when something worth recording happens, and buffers entries in a FIFO that a host or bench drains through a valid/ready port. It sits beside the b12 instance and provides a compact, replayable trace of observed responses.

## Interface
Parameters:
- `DEPTH`, 64: FIFO entries; power of two, at least 4.
- `TS_W`, 16: timestamp width in bits.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `arm` in 1: one-cycle pulse; starts a capture run.
- `stop` in 1: one-cycle pulse; ends a capture run.
- `obs` in 1: the `__obs` marker from the stimulus side.
- `nloss` in 1: b12 output.
- `nl` in 4: b12 output.
- `speaker` in 1: b12 output.
- `rd_ready` in 1: consumer accepts the head entry.
- `rd_valid` out 1: FIFO non-empty.
- `rd_data` out TS_W+7: head entry, `{ts, obs, nloss, nl[3:0], speaker}`, with `ts` in the MSBs.
- `level` out clog2(DEPTH)+1: current entry count.
- `overflow` out 1: sticky; an entry was dropped.
- `capturing` out 1: high while in CAPTURE.

## Operation
- States:
  - IDLE (after reset).
  - CAPTURE.
  - HALT.
- Transitions:
  - `arm` in IDLE or HALT goes to CAPTURE: `ts` is cleared to 0, `overflow` is cleared, and the first-cycle flag is set.
  - `arm` while already in CAPTURE is ignored.
  - `stop` in CAPTURE goes to HALT.
  - If `arm` and `stop` are asserted in the same cycle, `stop` wins. From IDLE or HALT the state is unchanged.
- Arming does not flush the FIFO. Entries from a previous run remain readable.
- Sample: `s = {nloss, nl, speaker}` (6 bits). `prev` holds the last sampled `s` and updates every CAPTURE cycle.
- Record condition, evaluated in CAPTURE only. Any one of these triggers a record:
  - first-cycle flag set;
  - `s != prev`;
  - `obs == 1`;
  - `ts == 0` because the timestamp wrapped.
- Timestamp: `ts` increments by 1 every CAPTURE cycle and wraps modulo 2^TS_W. The entry stores the value of `ts` before the increment. A forced record at wrap lets a reader count epochs.
- Write acceptance: the write is accepted if `level < DEPTH`, or if a pop happens in the same cycle. Otherwise the entry is dropped and `overflow` is set.
- Pop: occurs when `rd_valid && rd_ready`. `rd_ready` while empty has no effect.
- `level` update:
  - `level + push - pop`;
  - simultaneous push and pop leaves it unchanged;
  - it never exceeds DEPTH and never underflows.
- Pointers are clog2(DEPTH) bits and wrap naturally.
- HALT and IDLE never write; reads continue in every state.

## Timing
- Reset values:
  - `rd_valid` = 0
  - `rd_data` = 0
  - `level` = 0
  - `overflow` = 0
  - `capturing` = 0
  - state = IDLE; pointers, `ts`, `prev` and the first-cycle flag cleared.
- Reset mid-run discards all buffered entries.
- `arm` sampled at edge N puts the block in CAPTURE from edge N. The first sample is taken at edge N+1 with `ts = 0`.
- Input-to-read latency is 1 cycle: an entry written at edge N shows `rd_valid = 1` and matching `rd_data` after edge N, provided the FIFO was empty.
- `rd_data` is combinational from `mem[rd_ptr]`. It is stable while `rd_valid && !rd_ready`.
- `level` and `overflow` are registered and reflect the edge just taken.
- `stop` at edge N: no sample is recorded at edge N.

## Configuration
- `B12_TRACE_STOP_ON_FULL_EN`:
  - Defined: the first dropped entry also forces CAPTURE to HALT in the same edge, and `capturing` falls. This preserves the oldest contiguous trace.
  - Undefined: capture continues and later entries are recorded whenever space frees up; `overflow` still flags the gap.

## Test plan
- Reset, then `arm`; hold `nl = 4'h3` with all other inputs 0 for 10 cycles -> exactly one entry, `{ts = 0, obs = 0, nloss = 0, nl = 3, speaker = 0}`; `level = 1`.
- In CAPTURE, toggle `speaker` at capture cycles 5 and 8; pulse `obs` at cycle 12 with no output change -> entries with `ts` 0, 5, 8, 12; the `ts = 12` entry has `obs = 1`.
- With `TS_W = 4`, capture for 20 constant cycles -> entries with `ts = 0` at cycles 0 and 16; nothing else.
- `DEPTH = 4`, `rd_ready = 0`, change `nl` every cycle for 6 cycles -> `level = 4`, `overflow = 1`. With the macro, `capturing` drops on the 5th record. Without it, raising `rd_ready` for 1 cycle while `nl` changes -> `level` stays 4, and the new entry replaces the popped slot.
- Assert `reset` mid-run with `level = 3` -> next cycle all outputs 0 and state IDLE. `arm` and `stop` together in IDLE -> stays IDLE.
